// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a registered carry, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              cin,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] sum_out,
    output logic              cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic              ovf
`endif
);

    localparam int unsigned CntW = $clog2(DATA_W);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_sr_q, a_sr_d;
    logic [DATA_W-1:0] b_sr_q, b_sr_d;
    logic [DATA_W-1:0] sum_sr_q, sum_sr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [DATA_W-1:0] sum_out_q, sum_out_d;
    logic              cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    // Full-adder cell
    logic fa_sum;
    logic fa_count;

    assign fa_sum   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign fa_count = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        sum_sr_d  = sum_sr_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        sum_out_d = sum_out_q;
        cout_d    = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    a_sr_d   = in_a;
                    b_sr_d   = in_b;
                    carry_d  = cin;
                    cnt_d    = '0;
                    sum_sr_d = '0;
                    state_d  = StAdd;
                end
            end
            StAdd: begin
                carry_d  = fa_count;
                sum_sr_d = {fa_sum, sum_sr_q[DATA_W-1:1]};
                a_sr_d   = {1'b0, a_sr_q[DATA_W-1:1]};
                b_sr_d   = {1'b0, b_sr_q[DATA_W-1:1]};
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    // Result registers load on the final bit so they are valid during DONE.
                    sum_out_d = {fa_sum, sum_sr_q[DATA_W-1:1]};
                    cout_d    = fa_count;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d     = carry_q ^ fa_count;
`endif
                    state_d   = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= StIdle;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            sum_sr_q  <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            sum_out_q <= '0;
            cout_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            sum_sr_q  <= sum_sr_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            sum_out_q <= sum_out_d;
            cout_q    <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign ready   = (state_q != StAdd);
    assign busy    = (state_q == StAdd);
    assign done    = (state_q == StDone);
    assign sum_out = sum_out_q;
    assign cout    = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (DATA_W=8); ovf checks compile in with SERIAL_ADDER_OVF_EN.
module tb_serial_adder;

    localparam int W = 8;

    logic         sys_clk;
    logic         sys_rst_n;
    logic         start;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(
        .DATA_W(W)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .start    (start),
        .in_a     (in_a),
        .in_b     (in_b),
        .cin      (cin),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout     (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation; optionally pulses start with other operands at cycle glitch (0 = none).
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic [W:0] exp, input int glitch);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        int overlap  = 0;
        @(negedge sys_clk);
        start = 1'b1;
        in_a  = a;
        in_b  = b;
        cin   = c;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
        in_a  = 8'hC3;
        in_b  = 8'h5A;
        cin   = ~c;
        for (int i = 1; i <= W + 4; i++) begin
            @(negedge sys_clk);
            if (busy) busy_cnt++;
            if (busy && ready) overlap++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = i;
                    check({tag, " sum"}, 32'(sum_out), 32'(exp[W-1:0]));
                    check({tag, " cout"}, 32'(cout), 32'(exp[W]));
                    check({tag, " ready@done"}, 32'(ready), 32'd1);
                end
            end
            if (glitch != 0 && i == glitch) begin
                start = 1'b1;
                in_a  = 8'hAA;
                in_b  = 8'h55;
            end else if (glitch != 0 && i == glitch + 1) begin
                start = 1'b0;
            end
        end
        check({tag, " latency"}, 32'(done_at), 32'(W + 1));
        check({tag, " done count"}, 32'(done_cnt), 32'd1);
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(W));
        check({tag, " busy/ready overlap"}, 32'(overlap), 32'd0);
        check({tag, " sum held"}, 32'(sum_out), 32'(exp[W-1:0]));
    endtask

    initial begin
        int done_cnt;
        int d1;
        int d2;
        sys_rst_n = 1'b0;
        start     = 1'b0;
        in_a      = '0;
        in_b      = '0;
        cin       = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("rst ready", 32'(ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst sum", 32'(sum_out), 32'd0);
        check("rst cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst ovf", 32'(ovf), 32'd0);
`endif
        sys_rst_n = 1'b1;

        run_op("0F+01", 8'h0F, 8'h01, 1'b0, 9'h010, 0);
        run_op("FF+01", 8'hFF, 8'h01, 1'b0, 9'h100, 0);
        run_op("FF+FF+1", 8'hFF, 8'hFF, 1'b1, 9'h1FF, 0);
        run_op("12+34 ignore", 8'h12, 8'h34, 1'b0, 9'h046, 3);
        run_op("A5+5A+1", 8'hA5, 8'h5A, 1'b1, 9'h100, 0);

        // Back-to-back with start held high; second operands presented on the DONE cycle.
        @(negedge sys_clk);
        start    = 1'b1;
        in_a     = 8'h01;
        in_b     = 8'h02;
        cin      = 1'b0;
        done_cnt = 0;
        d1       = -1;
        d2       = -1;
        @(posedge sys_clk);
        for (int i = 1; i <= 2 * W + 6; i++) begin
            @(negedge sys_clk);
            if (done) begin
                done_cnt++;
                if (d1 < 0) begin
                    d1 = i;
                    check("b2b first sum", 32'(sum_out), 32'h03);
                    in_a = 8'h10;
                    in_b = 8'h20;
                end else if (d2 < 0) begin
                    d2 = i;
                    check("b2b second sum", 32'(sum_out), 32'h30);
                    check("b2b second cout", 32'(cout), 32'd0);
                end
            end
            if (d1 > 0 && i == d1 + 1) start = 1'b0;
        end
        check("b2b first latency", 32'(d1), 32'(W + 1));
        check("b2b done spacing", 32'(d2 - d1), 32'(W + 1));
        check("b2b done count", 32'(done_cnt), 32'd2);

        // Reset asserted during the 4th ADD cycle.
        @(negedge sys_clk);
        start = 1'b1;
        in_a  = 8'h33;
        in_b  = 8'h11;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check("midrst ready", 32'(ready), 32'd1);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst sum", 32'(sum_out), 32'd0);
        check("midrst cout", 32'(cout), 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        done_cnt  = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge sys_clk);
            if (done) done_cnt++;
        end
        check("midrst no done", 32'(done_cnt), 32'd0);
        run_op("05+05", 8'h05, 8'h05, 1'b0, 9'h00A, 0);

`ifdef SERIAL_ADDER_OVF_EN
        run_op("7F+01", 8'h7F, 8'h01, 1'b0, 9'h080, 0);
        check("7F+01 ovf", 32'(ovf), 32'd1);
        run_op("FF+01 ovf", 8'hFF, 8'h01, 1'b0, 9'h100, 0);
        check("FF+01 ovf", 32'(ovf), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
